// File: rtl/mips_muldiv_pkg.sv
// Shared op codes, state type and sign helpers for the MIPS HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  // Widest vector the sign helper handles; the full product is 2*WIDTH bits.
  localparam int MD_MAX_W = 128;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Two's-complement negate when requested. Absolute value is condNeg(x, sign(x)).
  function automatic logic [MD_MAX_W-1:0] condNeg(input logic [MD_MAX_W-1:0] value,
                                                  input logic               negate);
    return negate ? (~value + MD_MAX_W'(1)) : value;
  endfunction

  function automatic logic isSignedOp(input logic [2:0] opCode);
    return (opCode == MD_MULT) || (opCode == MD_DIV);
  endfunction

  function automatic logic isMulDivOp(input logic [2:0] opCode);
    return (opCode == MD_MULT) || (opCode == MD_MULTU) ||
           (opCode == MD_DIV)  || (opCode == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_iter_step.sv
// One radix-2^BITS_PER_CYCLE step: shift-add multiply or restoring divide on magnitudes.
module muldiv_iter_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_hiAcc,
  input  logic [WIDTH-1:0] i_loAcc,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hiAcc,
  output logic [WIDTH-1:0] o_loAcc
);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;

  // Mult keeps {partial product, multiplier} and shifts right; div keeps
  // {remainder, dividend/quotient} and shifts left, one bit per unrolled pass.
  always_comb begin
    w_hi     = i_hiAcc;
    w_lo     = i_loAcc;
    w_addend = '0;
    w_sum    = '0;
    w_shift  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (i_isDiv) begin
        w_shift = {w_hi, w_lo[WIDTH-1]};
        if (w_shift >= {1'b0, i_operand}) begin
          w_hi = w_shift[WIDTH-1:0] - i_operand;
          w_lo = {w_lo[WIDTH-2:0], 1'b1};
        end else begin
          w_hi = w_shift[WIDTH-1:0];
          w_lo = {w_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        w_addend = w_lo[0] ? i_operand : '0;
        w_sum    = {1'b0, w_hi} + {1'b0, w_addend};
        w_hi     = w_sum[WIDTH:1];
        w_lo     = {w_sum[0], w_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hiAcc = w_hi;
  assign o_loAcc = w_lo;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_STEP = CW'(BITS_PER_CYCLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - BITS_PER_CYCLE);

  md_state_e        r_state;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_isDiv;
  logic             r_negA;
  logic             r_negB;
  logic [WIDTH-1:0] r_rawA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_hiAcc;
  logic [WIDTH-1:0] r_loAcc;

  logic             w_signedOp;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_stepHi;
  logic [WIDTH-1:0] w_stepLo;
  logic [PW-1:0]    w_prodFix;
  logic [WIDTH-1:0] w_quotFix;
  logic [WIDTH-1:0] w_remFix;
  logic [WIDTH-1:0] w_fixHi;
  logic [WIDTH-1:0] w_fixLo;

  assign w_signedOp = isSignedOp(op);
  assign w_absA = WIDTH'(condNeg(MD_MAX_W'(op_a), w_signedOp & op_a[WIDTH-1]));
  assign w_absB = WIDTH'(condNeg(MD_MAX_W'(op_b), w_signedOp & op_b[WIDTH-1]));

  muldiv_iter_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_isDiv   (r_isDiv),
    .i_hiAcc   (r_hiAcc),
    .i_loAcc   (r_loAcc),
    .i_operand (r_opB),
    .o_hiAcc   (w_stepHi),
    .o_loAcc   (w_stepLo)
  );

  // Remainder follows the dividend's sign; quotient and product follow sign(a)^sign(b).
  assign w_prodFix = PW'(condNeg(MD_MAX_W'({r_hiAcc, r_loAcc}), r_negA ^ r_negB));
  assign w_quotFix = WIDTH'(condNeg(MD_MAX_W'(r_loAcc), r_negA ^ r_negB));
  assign w_remFix  = WIDTH'(condNeg(MD_MAX_W'(r_hiAcc), r_negA));

  always_comb begin
    w_fixHi = w_prodFix[PW-1:WIDTH];
    w_fixLo = w_prodFix[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_opB == '0) begin
        w_fixHi = r_rawA;
        w_fixLo = '1;
      end else begin
        w_fixHi = w_remFix;
        w_fixLo = w_quotFix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_isDiv <= 1'b0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_rawA  <= '0;
      r_opB   <= '0;
      r_hiAcc <= '0;
      r_loAcc <= '0;
    end else begin
      r_done <= 1'b0;
      if (!hold) begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (op == MD_MTHI) begin
                r_hi <= op_a;
              end else if (op == MD_MTLO) begin
                r_lo <= op_a;
              end else if (isMulDivOp(op)) begin
                r_isDiv <= (op == MD_DIV) || (op == MD_DIVU);
                r_negA  <= w_signedOp & op_a[WIDTH-1];
                r_negB  <= w_signedOp & op_b[WIDTH-1];
                r_rawA  <= op_a;
                r_opB   <= w_absB;
                r_hiAcc <= '0;
                r_loAcc <= w_absA;
                r_count <= '0;
                r_busy  <= 1'b1;
                r_state <= CALC;
              end
            end
          end
          CALC: begin
            r_hiAcc <= w_stepHi;
            r_loAcc <= w_stepLo;
            r_count <= r_count + CNT_STEP;
            if (r_count == CNT_LAST) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            r_hi    <= w_fixHi;
            r_lo    <= w_fixLo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomised and directed checks of mips_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic        clk;
  logic        rst_b;
  logic        start, hold;
  logic [2:0]  op;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start4, hold4;
  logic [2:0]  op4;
  logic [31:0] opA4, opB4;
  logic        busy4, done4;
  logic [31:0] hi4, lo4;

  int checks;
  int errors;

  mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .op_a(opA), .op_b(opB),
    .hold(hold), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .start(start4), .op(op4), .op_a(opA4), .op_b(opB4),
    .hold(hold4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference {hi, lo} from ordinary integer arithmetic (SV / and % truncate toward zero).
  function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    case (o)
      MD_MULT:  begin sp = sa * sb; p = sp; end
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin q = 32'(sa / sb); r = 32'(sa % sb); p = {r, q}; end
      end
      MD_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic issueAndWait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int cycles);
    @(negedge clk); start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk); #1; start = 1'b0;
    cycles = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin cycles = n; break; end
    end
  endtask

  task automatic issueAndWait4(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int cycles);
    @(negedge clk); start4 = 1'b1; op4 = o; opA4 = a; opB4 = b;
    @(posedge clk); #1; start4 = 1'b0;
    cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done4) begin cycles = n; break; end
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clk); rst_b = 1'b1;
  endtask

  logic [2:0]  dOp  [6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
  logic [31:0] dA   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'hFFFF_FFF0};
  logic [31:0] dB   [6] = '{32'h2, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] dHi  [6] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h7, 32'h0, 32'hFFFF_FFF0};
  logic [31:0] dLo  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  task automatic test_directed;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issueAndWait(dOp[i], dA[i], dB[i], cyc);
      checks += 4;
      if (cyc != 33) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected 33", i, cyc); end
      if (hi !== dHi[i]) begin errors++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, hi, dHi[i]); end
      if (lo !== dLo[i]) begin errors++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, lo, dLo[i]); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_busy_at_done: got %b expected 0", i, busy); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL directed%0d_done_width: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_mthi_mtlo;
    int sawDone;
    sawDone = 0;
    @(negedge clk); start = 1'b1; op = MD_MTHI; opA = 32'h1234; opB = 32'h0;
    @(posedge clk); #1; sawDone += int'(done);
    op = MD_MTLO; opA = 32'hABCD;
    @(posedge clk); #1; sawDone += int'(done);
    start = 1'b0;
    @(posedge clk); #1; sawDone += int'(done);
    checks += 4;
    if (hi !== 32'h1234) begin errors++; $display("[TB] FAIL mthi_value: got %h expected 00001234", hi); end
    if (lo !== 32'hABCD) begin errors++; $display("[TB] FAIL mtlo_value: got %h expected 0000abcd", lo); end
    if (sawDone != 0) begin errors++; $display("[TB] FAIL mtx_no_done: got %0d pulses expected 0", sawDone); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtx_busy: got %b expected 0", busy); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] a, b;
    logic [63:0] expv;
    int cyc;
    a = $urandom; b = $urandom;
    expv = refResult(MD_MULT, a, b);
    @(negedge clk); start = 1'b1; op = MD_MULT; opA = a; opB = b;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (n == 5) begin op = MD_DIVU; opA = 32'd100; opB = 32'd7; end
      @(posedge clk); #1; start = 1'b0;
      if (done) begin cyc = n; break; end
    end
    checks += 3;
    if (cyc != 33) begin errors++; $display("[TB] FAIL busy_ignore_latency: got %0d expected 33", cyc); end
    if (hi !== expv[63:32]) begin errors++; $display("[TB] FAIL busy_ignore_hi: got %h expected %h", hi, expv[63:32]); end
    if (lo !== expv[31:0]) begin errors++; $display("[TB] FAIL busy_ignore_lo: got %h expected %h", lo, expv[31:0]); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_no_queue: got %b expected 0", busy); end
  endtask

  task automatic test_hold;
    int cyc;
    @(negedge clk); start = 1'b1; op = MD_MULTU; opA = 32'd3; opB = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk); hold = ((n >= 3) && (n <= 6)) || (n == 37);
      @(posedge clk); #1;
      if (done) begin cyc = n; break; end
    end
    hold = 1'b0;
    checks += 3;
    if (cyc != 38) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 38", cyc); end
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL hold_hi: got %h expected 0", hi); end
    if (lo !== 32'd15) begin errors++; $display("[TB] FAIL hold_lo: got %h expected 0000000f", lo); end
  endtask

  task automatic test_idle_ignores;
    logic [31:0] hiBefore, loBefore;
    hiBefore = hi; loBefore = lo;
    @(negedge clk); hold = 1'b1; start = 1'b1; op = MD_MTHI; opA = ~hiBefore;
    @(posedge clk); #1; op = MD_MULT;
    @(posedge clk); #1; start = 1'b0; hold = 1'b0;
    checks += 2;
    if (hi !== hiBefore) begin errors++; $display("[TB] FAIL hold_idle_mthi: got %h expected %h", hi, hiBefore); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_idle_mult: got %b expected 0", busy); end
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk); start = 1'b1; op = 3'(k); opA = 32'hDEAD_BEEF; opB = 32'h3;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal%0d_busy: got %b expected 0", k, busy); end
      if (hi !== hiBefore) begin errors++; $display("[TB] FAIL illegal%0d_hi: got %h expected %h", k, hi, hiBefore); end
      if (lo !== loBefore) begin errors++; $display("[TB] FAIL illegal%0d_lo: got %h expected %h", k, lo, loBefore); end
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] expv;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(3, 0));
      case ($urandom_range(7, 0))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(100, 0);
        default: a = $urandom;
      endcase
      case ($urandom_range(7, 0))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(20, 1);
        default: b = $urandom;
      endcase
      expv = refResult(o, a, b);
      issueAndWait(o, a, b, cyc);
      checks += 3;
      if (cyc != 33) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 33", i, cyc); end
      if (hi !== expv[63:32]) begin errors++; $display("[TB] FAIL rand%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, expv[63:32]); end
      if (lo !== expv[31:0]) begin errors++; $display("[TB] FAIL rand%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, expv[31:0]); end
    end
  endtask

  task automatic test_reset_midop;
    int cyc;
    @(negedge clk); start = 1'b1; op = MD_MTHI; opA = 32'h55;
    @(negedge clk); op = MD_MTLO; opA = 32'h66;
    @(negedge clk); op = MD_MULT; opA = $urandom; opB = $urandom;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2; rst_b = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_done: got %b expected 0", done); end
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_hi: got %h expected 0", hi); end
    if (lo !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_lo: got %h expected 0", lo); end
    @(negedge clk); rst_b = 1'b1;
    issueAndWait(MD_MULTU, 32'd3, 32'd5, cyc);
    checks += 3;
    if (cyc != 33) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 33", cyc); end
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_hi: got %h expected 0", hi); end
    if (lo !== 32'd15) begin errors++; $display("[TB] FAIL post_reset_lo: got %h expected 0000000f", lo); end
  endtask

  task automatic test_radix4;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] expv;
    int cyc;
    issueAndWait4(MD_MULTU, 32'd3, 32'd5, cyc);
    checks += 3;
    if (cyc != 9) begin errors++; $display("[TB] FAIL radix4_latency: got %0d expected 9", cyc); end
    if (hi4 !== 32'h0) begin errors++; $display("[TB] FAIL radix4_hi: got %h expected 0", hi4); end
    if (lo4 !== 32'd15) begin errors++; $display("[TB] FAIL radix4_lo: got %h expected 0000000f", lo4); end
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(3, 0));
      a = (i == 0) ? 32'h8000_0000 : $urandom;
      b = (i == 0) ? 32'hFFFF_FFFF : ((i == 1) ? 32'h0 : $urandom);
      expv = refResult(o, a, b);
      issueAndWait4(o, a, b, cyc);
      checks += 3;
      if (cyc != 9) begin errors++; $display("[TB] FAIL radix4_rand%0d_latency: got %0d expected 9", i, cyc); end
      if (hi4 !== expv[63:32]) begin errors++; $display("[TB] FAIL radix4_rand%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi4, expv[63:32]); end
      if (lo4 !== expv[31:0]) begin errors++; $display("[TB] FAIL radix4_rand%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo4, expv[31:0]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_b = 1'b0; start = 1'b0; hold = 1'b0; op = 3'd0; opA = '0; opB = '0;
    start4 = 1'b0; hold4 = 1'b0; op4 = 3'd0; opA4 = '0; opB4 = '0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_hold();
    test_idle_ignores();
    test_random();
    test_reset_midop();
    test_radix4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit holding the MIPS HI/LO architectural registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the core's single-cycle ALU and is driven from decode. The core reads HI/LO directly for MFHI/MFLO and stalls on busy. Operand width and per-edge iteration count are parametrised; the single-cycle ALU has neither multi-cycle operation nor HI/LO state.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be even and ≥ 4.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC edge; legal values 1, 2, 4; WIDTH must be divisible by it.

Ports:
clk  input  1  clock, rising-edge
rst_b  input  1  reset, asynchronous, active-low
start  input  1  launch op; sampled only while busy=0
op  input  3  operation code, values in mips_muldiv_pkg
op_a  input  WIDTH  rs operand (multiplicand/dividend, or MTHI/MTLO source)
op_b  input  WIDTH  rt operand (multiplier/divisor)
hold  input  1  freeze: no state, counter or HI/LO change while high
busy  output  1  high while an operation is in CALC or FIX
done  output  1  single-cycle pulse when HI/LO take a mult/div result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. rst_b is asynchronous and active-low. While rst_b=0: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation with no partial result.
- States: IDLE, CALC, FIX.
- IDLE, start=1, hold=0, op=MTHI: hi<=op_a at that edge. lo, busy and done are unchanged; done stays 0.
- IDLE, start=1, hold=0, op=MTLO: as MTHI, but lo<=op_a.
- IDLE, start=1, hold=0, op in {MULT, MULTU, DIV, DIVU}: latch the operands, their signs and the op; counter<=0; go to CALC. busy=1 from the next cycle.
- Signed ops (MULT, DIV) operate on absolute values. Sign fix-up happens in FIX.
- CALC, each non-held edge: retire BITS_PER_CYCLE bits using shift-add (mult) or restoring subtract (div). counter += BITS_PER_CYCLE. When the counter reaches WIDTH, go to FIX.
- FIX, next non-held edge: apply sign correction, write hi/lo, go to IDLE. done=1 for exactly the following cycle. busy drops in the same cycle that done rises.
- Latency: start accepted at edge E0; done is high during the cycle after edge E0 + WIDTH/BITS_PER_CYCLE + 1. Every held cycle adds one cycle.
- Mult result: full 2·WIDTH product; hi = upper half, lo = lower half. MULT negates the product when the operand signs differ.
- Div result: lo = quotient, hi = remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign follows the dividend (truncating division).
- Divide by zero (op_b=0, DIV or DIVU): hi=op_a and lo=all-ones, regardless of sign. Same latency as a normal divide. No exception is raised.
- Signed overflow (DIV of the most-negative value by -1): lo=most-negative value, hi=0.
- start while busy=1: ignored; no queueing.
- hold=1 in IDLE: start is ignored, including MTHI/MTLO.
- done never asserts while hold=1. If hold rises in FIX, the write and the done pulse wait until hold falls.
- Illegal op codes: start is ignored; state stays IDLE.

Decomposition:
- Package mips_muldiv_pkg:
  - op typedef: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State typedef: IDLE, CALC, FIX.
  - Helper function for absolute value and conditional negate.
- Sub-module muldiv_iter_step: combinational, one radix-2^BITS_PER_CYCLE step for mult or div. It is instantiated once; the top holds the FSM, counter and HI/LO flops.

Test Plan:
(All values WIDTH=32, BITS_PER_CYCLE=1.)
- MULT a=0xFFFFFFFF, b=2 -> done at E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0xABCD on consecutive edges -> hi=0x1234 and lo=0xABCD with no done pulse. A second start issued 5 cycles into a MULT -> ignored; HI/LO reflect only the first op.
- hold=1 for 4 cycles during CALC, plus 1 cycle during FIX -> done at E0+38, with the correct product 3*5: hi=0, lo=15.
- rst_b low asynchronously mid-CALC -> busy, done, hi and lo read 0 before the next edge. After release, a fresh MULTU 3*5 gives lo=15. Repeat with BITS_PER_CYCLE=4 -> done at E0+9.
